// File: rtl/field_deposit_unit_if.sv
// Request/response bundle for the bit-field deposit unit.
// Vectors are [N-1:0]; big-endian bit i of a word is vector bit WIDTH-1-i.
interface field_deposit_unit_if #(
   parameter int WIDTH = 32,
   parameter int POS_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] len;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             ovf;
   logic             clip;

   modport master (
      output in_valid, a, b, pos, len, sgn, out_ready,
      input  in_ready, out_valid, y, ovf, clip
   );

   modport slave (
      input  in_valid, a, b, pos, len, sgn, out_ready,
      output in_ready, out_valid, y, ovf, clip
   );
endinterface

// File: rtl/field_deposit_unit.sv
// Two-stage bit-field deposit: inserts the low LEN bits of b into a, ending at
// big-endian bit pos, with a signed/unsigned fit check and a clip flag.
module field_deposit_unit #(
   parameter int WIDTH = 32,
   parameter int POS_W = 5
) (
   input logic                 clk,
   input logic                 rst,
   field_deposit_unit_if.slave bus
);

   localparam logic [POS_W:0] FULL_LEN = WIDTH[POS_W:0];
   localparam logic [POS_W:0] ONE_EXT  = 1;

   function automatic logic [WIDTH-1:0] field_mask(input logic [POS_W:0] flen);
      if (flen == FULL_LEN) field_mask = '1;
      else                  field_mask = (WIDTH'(1) << flen) - WIDTH'(1);
   endfunction

   // Fit check: signed compares against the sign-extension of the low flen bits.
   function automatic logic range_ovf(input logic [WIDTH-1:0] val,
                                      input logic [POS_W:0]   flen,
                                      input logic             is_signed);
      logic [POS_W:0]          drop;
      logic signed [WIDTH-1:0] sext;
      drop = FULL_LEN - flen;
      sext = $signed(val << drop) >>> drop;
      if (is_signed) range_ovf = (sext != $signed(val));
      else           range_ovf = (flen != FULL_LEN) && ((val >> flen) != '0);
   endfunction

   logic             vld_p1_q, vld_p1_d;
   logic             vld_p2_q, vld_p2_d;
   logic             adv_p2, accept, move_p2, in_ready;

   logic [POS_W:0]   len_ext;
   logic [POS_W-1:0] shamt;
   logic [WIDTH-1:0] fmask_p1_d, bsh_p1_d;
   logic             ovf_p1_d, clip_p1_d;

   logic [WIDTH-1:0] a_p1_q, fmask_p1_q, bsh_p1_q;
   logic             ovf_p1_q, clip_p1_q;

   logic [WIDTH-1:0] y_p2_q, y_p2_d;
   logic             ovf_p2_q, ovf_p2_d;
   logic             clip_p2_q, clip_p2_d;

   // Stage 2 advances when it is empty or its result is being taken.
   always_comb begin
      adv_p2   = !vld_p2_q || bus.out_ready;
      in_ready = rst && (!vld_p1_q || adv_p2);
      accept   = bus.in_valid && in_ready;
      move_p2  = vld_p1_q && adv_p2;
      vld_p1_d = accept || (vld_p1_q && !adv_p2);
      vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
   end

   // ---- stage 1: field geometry, shifted operand, range flags ----
   always_comb begin
      len_ext    = (bus.len == '0) ? FULL_LEN : {1'b0, bus.len};
      shamt      = POS_W'(WIDTH - 1) - bus.pos;
      fmask_p1_d = field_mask(len_ext) << shamt;
      bsh_p1_d   = bus.b << shamt;
      ovf_p1_d   = range_ovf(bus.b, len_ext, bus.sgn);
      clip_p1_d  = len_ext > ({1'b0, bus.pos} + ONE_EXT);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1_q     <= bus.a;
         fmask_p1_q <= fmask_p1_d;
         bsh_p1_q   <= bsh_p1_d;
         ovf_p1_q   <= ovf_p1_d;
         clip_p1_q  <= clip_p1_d;
      end
   end

   // ---- stage 2: merge into target word ----
   always_comb begin
      y_p2_d    = y_p2_q;
      ovf_p2_d  = ovf_p2_q;
      clip_p2_d = clip_p2_q;
      if (move_p2) begin
         y_p2_d    = (a_p1_q & ~fmask_p1_q) | (bsh_p1_q & fmask_p1_q);
         ovf_p2_d  = ovf_p1_q;
         clip_p2_d = clip_p1_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         y_p2_q    <= '0;
         ovf_p2_q  <= 1'b0;
         clip_p2_q <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         y_p2_q    <= y_p2_d;
         ovf_p2_q  <= ovf_p2_d;
         clip_p2_q <= clip_p2_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_p2_q;
   assign bus.y         = y_p2_q;
   assign bus.ovf       = ovf_p2_q;
   assign bus.clip      = clip_p2_q;

endmodule

// File: tb/tb_field_deposit_unit.sv
// Bench for field_deposit_unit: directed vector table, pipeline corner
// sequences, and randomized traffic against a bit-level reference model.
`timescale 1ns/1ps
module tb_field_deposit_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   field_deposit_unit_if bus ();
   field_deposit_unit dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] a, b;
      logic [4:0]  pos, len;
      logic        sgn;
      logic [31:0] y;
      logic        ovf, clip;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic        ovf, clip;
      int          acc_cyc;
   } exp_t;

   vec_t  tbl [12];
   exp_t  q [$];
   int    n_chk, n_pass, n_fail, cyc_no, n_del;
   logic  strict_lat, last_acc;
   logic  prev_stall, prev_o, prev_c;
   logic [31:0] prev_y;
   logic [31:0] nx_y;
   logic        nx_o, nx_c;
   string tag;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: walk the field bit by bit in big-endian positions; range by arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] pos, input logic [4:0] len,
                                 input logic sgn, output logic [31:0] y,
                                 output logic o, output logic c);
      int     L, p, be;
      longint sv, uv, lim;
      L = (len == 0) ? 32 : int'(len);
      p = int'(pos);
      y = a;
      for (int k = 0; k < L; k++) begin
         be = p - k;
         if (be >= 0) y[31-be] = b[k];
      end
      sv  = longint'($signed(b));
      uv  = longint'({32'd0, b});
      lim = longint'(1) << (L - 1);
      if (sgn) o = (sv < -lim) || (sv >= lim);
      else     o = (uv >= (longint'(1) << L));
      c = (L > p + 1);
   endfunction

   task automatic set_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] pos, input logic [4:0] len, input logic sgn);
      bus.a = a; bus.b = b; bus.pos = pos; bus.len = len; bus.sgn = sgn;
      model(a, b, pos, len, sgn, nx_y, nx_o, nx_c);
   endtask

   task automatic set_rand();
      logic [31:0] rb;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      set_req($urandom, rb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)));
   endtask

   // One clock: called just after a falling edge with inputs set; returns at the next one.
   task automatic cyc();
      exp_t e;
      #1;
      if (prev_stall) begin
         chk({tag, "_stall_y"}, bus.y, prev_y);
         chk({tag, "_stall_flags"}, {bus.out_valid, bus.ovf, bus.clip}, {1'b1, prev_o, prev_c});
      end
      if (q.size() == 0) chk({tag, "_no_stale_out"}, bus.out_valid, 0);
      last_acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
         e = q.pop_front();
         chk({tag, "_y"}, bus.y, e.y);
         chk({tag, "_ovf_clip"}, {bus.ovf, bus.clip}, {e.ovf, e.clip});
         if (strict_lat) chk({tag, "_latency"}, cyc_no - e.acc_cyc, 2);
         n_del++;
      end
      if (last_acc) begin
         e.y = nx_y; e.ovf = nx_o; e.clip = nx_c; e.acc_cyc = cyc_no;
         q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y = bus.y; prev_o = bus.ovf; prev_c = bus.clip;
      cyc_no++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, acc_bits;
      tbl[0]  = '{32'h0,        32'h000000FF, 5'd31, 5'd8,  1'b1, 32'h000000FF, 1'b1, 1'b0};
      tbl[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, 5'd8,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
      tbl[2]  = '{32'hFFFFFFFF, 32'h0,        5'd23, 5'd8,  1'b0, 32'hFFFF00FF, 1'b0, 1'b0};
      tbl[3]  = '{32'h12345678, 32'h0000ABCD, 5'd15, 5'd16, 1'b0, 32'hABCD5678, 1'b0, 1'b0};
      tbl[4]  = '{32'h12345678, 32'hDEADBEEF, 5'd31, 5'd0,  1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[5]  = '{32'h12345678, 32'hDEADBEEF, 5'd3,  5'd8,  1'b0, 32'hF2345678, 1'b1, 1'b1};
      tbl[6]  = '{32'h0,        32'hFFFFFF80, 5'd31, 5'd8,  1'b1, 32'h00000080, 1'b0, 1'b0};
      tbl[7]  = '{32'h0,        32'h00000080, 5'd31, 5'd8,  1'b1, 32'h00000080, 1'b1, 1'b0};
      tbl[8]  = '{32'h0,        32'h00000100, 5'd31, 5'd8,  1'b0, 32'h00000000, 1'b1, 1'b0};
      tbl[9]  = '{32'h0,        32'hFFFFFFFF, 5'd0,  5'd1,  1'b1, 32'h80000000, 1'b0, 1'b0};
      tbl[10] = '{32'hAAAAAAAA, 32'h00000005, 5'd1,  5'd3,  1'b0, 32'h6AAAAAAA, 1'b0, 1'b1};
      tbl[11] = '{32'h0,        32'h80000000, 5'd31, 5'd0,  1'b1, 32'h80000000, 1'b0, 1'b0};

      n_chk = 0; n_pass = 0; n_fail = 0; cyc_no = 0; n_del = 0;
      strict_lat = 1'b1; prev_stall = 1'b0; tag = "reset";
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      set_req(32'h0, 32'h0, 5'd0, 5'd0, 1'b0);

      #2;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_y", bus.y, 0);
      chk("reset_flags", {bus.ovf, bus.clip}, 0);
      chk("reset_in_ready", bus.in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("post_reset_in_ready", bus.in_ready, 1);
      @(negedge clk);

      // Directed vectors, one request at a time.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tag = $sformatf("vec%0d", i);
         set_req(tbl[i].a, tbl[i].b, tbl[i].pos, tbl[i].len, tbl[i].sgn);
         nx_y = tbl[i].y; nx_o = tbl[i].ovf; nx_c = tbl[i].clip;
         bus.in_valid = 1'b1;
         cyc();
         chk({tag, "_accept"}, last_acc, 1);
         bus.in_valid = 1'b0;
         cyc();
         cyc();
      end

      // Back-to-back stream of four.
      tag = "burst"; d0 = n_del;
      for (int i = 0; i < 4; i++) begin
         set_rand();
         bus.in_valid = 1'b1;
         cyc();
         chk("burst_accept", last_acc, 1);
      end
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      chk("burst_delivered", n_del - d0, 4);

      // Stall with three requests offered, then release.
      tag = "stall"; strict_lat = 1'b0; d0 = n_del; acc_bits = 0;
      bus.out_ready = 1'b0;
      set_rand();
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         acc_bits = (acc_bits << 1) | int'(last_acc);
         if (last_acc) set_rand();
      end
      chk("stall_accept_pattern", acc_bits, 3'b110);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (last_acc) bus.in_valid = 1'b0;
      end
      chk("stall_delivered", n_del - d0, 3);
      chk("stall_queue_empty", q.size(), 0);

      // Asynchronous reset with both stages full.
      tag = "midrst";
      bus.out_ready = 1'b0;
      set_rand(); bus.in_valid = 1'b1; cyc();
      set_rand(); cyc();
      bus.in_valid = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_y", bus.y, 0);
      chk("midrst_flags", {bus.ovf, bus.clip}, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) cyc();
      strict_lat = 1'b1; d0 = n_del;
      set_rand(); bus.in_valid = 1'b1; cyc();
      chk("midrst_new_accept", last_acc, 1);
      bus.in_valid = 1'b0;
      cyc(); cyc();
      chk("midrst_new_delivered", n_del - d0, 1);

      // Randomized traffic with random backpressure.
      tag = "rand"; strict_lat = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
            set_rand();
            bus.in_valid = 1'b1;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
         if (last_acc) bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      while (bus.in_valid) begin
         cyc();
         if (last_acc) bus.in_valid = 1'b0;
      end
      for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
      chk("rand_drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
